// File: rtl/matrix_mult3x3_seq_if.sv
// Register bus between a host and matrix_mult3x3_seq.
// Strobes are single-cycle; read data carries a valid bit in its MSB.
interface matrix_mult3x3_seq_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        bus_addr;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rd;
    logic [DATA_W:0]   bus_rdata;

    modport master (
        output bus_addr, bus_wr, bus_wdata, bus_rd,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wr, bus_wdata, bus_rd,
        output bus_rdata
    );
endinterface

// File: rtl/matrix_mult3x3_seq.sv
// Sequencer feeding 3x3 coefficients to a multiply core and capturing results.
// Optional WAIT/CAPTURE watchdog: define MATRIX_MULT3X3_SEQ_TIMEOUT_EN.
module matrix_mult3x3_seq #(
    parameter int DATA_W      = 32,
    parameter int N_WORDS     = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 system1000,
    input  logic                 system1000_rst,
    matrix_mult3x3_seq_if.slave  bus,
    output logic [DATA_W:0]      core_in,
    input  logic [DATA_W:0]      core_out,
    output logic                 busy,
    output logic                 done_irq
);
    localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [4:0] A_STAT = 5'd31;
    localparam logic [4:0] A_RES  = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_k;
    logic [CW-1:0]     r_j;
    logic [DATA_W-1:0] r_coef [N_WORDS];
    logic [DATA_W-1:0] r_result [N_WORDS];
    logic [4:1]        r_sticky;
    logic [4:1]        w_set;
    logic [4:1]        w_clr;
    logic [4:1]        w_sticky_nxt;
    logic [DATA_W:0]   r_rdata;
    logic [DATA_W-1:0] w_rd_val;

    logic          w_cv;
    logic          w_idle;
    logic          w_waiting;
    logic          w_stat_wr;
    logic          w_start;
    logic          w_coef_wr;
    logic          w_cap_en;
    logic          w_last_j;
    logic          w_last_k;
    logic          w_tmo;
    logic [CW-1:0] w_cidx;
    logic [CW-1:0] w_ridx;

    assign w_cv      = core_out[DATA_W];
    assign w_idle    = (r_state == S_IDLE);
    assign w_waiting = (r_state == S_WAIT) || (r_state == S_CAPTURE);
    assign w_stat_wr = bus.bus_wr && (bus.bus_addr == A_STAT);
    assign w_start   = w_stat_wr && bus.bus_wdata[0];
    assign w_coef_wr = bus.bus_wr && (int'(bus.bus_addr) < N_WORDS);
    assign w_cap_en  = w_waiting && w_cv;
    assign w_last_j  = (r_j == CW'(N_WORDS - 1));
    assign w_last_k  = (r_k == CW'(N_WORDS - 1));
    assign w_cidx    = CW'(bus.bus_addr);
    assign w_ridx    = CW'(bus.bus_addr - A_RES);

`ifdef MATRIX_MULT3X3_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo;

    // Count silent core cycles while results are outstanding
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) r_tmo <= '0;
        else if (w_waiting && !w_cv) r_tmo <= r_tmo + TW'(1);
        else r_tmo <= '0;
    end

    assign w_tmo = w_waiting && !w_cv &&
                   (r_tmo == TW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign w_tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_LOAD;
            S_LOAD:    if (w_last_k) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_cv) w_state_nxt = w_last_j ? S_DONE : S_CAPTURE;
                else if (w_tmo) w_state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                if (w_cv && w_last_j) w_state_nxt = S_DONE;
                else if (w_tmo) w_state_nxt = S_IDLE;
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign busy     = !w_idle;
    assign done_irq = (r_state == S_DONE);
    assign core_in  = (r_state == S_LOAD) ? {1'b1, r_coef[r_k]} : '0;

    // Counters, coefficient bank and result capture
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_k <= '0;
            r_j <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                r_coef[i]   <= '0;
                r_result[i] <= '0;
            end
        end else begin
            if (w_idle && w_start) begin
                r_k <= '0;
                r_j <= '0;
            end else if (r_state == S_LOAD) begin
                r_k <= r_k + CW'(1);
            end
            if (w_cap_en) begin
                r_result[r_j] <= core_out[DATA_W-1:0];
                r_j           <= r_j + CW'(1);
            end
            if (w_coef_wr && w_idle) r_coef[w_cidx] <= bus.bus_wdata;
        end
    end

    // Sticky set/clear; a set in the same cycle beats the clear
    always_comb begin
        w_set    = '0;
        w_set[1] = (r_state == S_DONE);
        w_set[2] = (w_start || w_coef_wr) && !w_idle;
        w_set[3] = w_cv && !w_waiting;
        w_set[4] = w_tmo;
        w_clr    = w_stat_wr ? bus.bus_wdata[4:1] : '0;
        w_sticky_nxt = (r_sticky & ~w_clr) | w_set;
    end

    // Sticky status register
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) r_sticky <= '0;
        else r_sticky <= w_sticky_nxt;
    end

    // Read mux sees same-cycle writes so a write+read returns new data
    always_comb begin
        w_rd_val = '0;
        if (bus.bus_addr == A_STAT) begin
            w_rd_val = DATA_W'({w_sticky_nxt, w_state_nxt != S_IDLE});
        end else if (int'(bus.bus_addr) < N_WORDS) begin
            w_rd_val = (w_coef_wr && w_idle) ? bus.bus_wdata
                                             : r_coef[w_cidx];
        end else if (bus.bus_addr >= A_RES &&
                     int'(bus.bus_addr) < int'(A_RES) + N_WORDS) begin
            w_rd_val = r_result[w_ridx];
        end
    end

    // One-cycle read response register
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) r_rdata <= '0;
        else if (bus.bus_rd) r_rdata <= {1'b1, w_rd_val};
        else r_rdata <= '0;
    end

    assign bus.bus_rdata = r_rdata;
endmodule

// File: doc/matrix_mult3x3_seq.md
MATRIX_MULT3X3_SEQ -- requirements
Module: matrix_mult3x3_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the coefficient and result word width.
REQ-002 The block SHALL have parameter N_WORDS, default 9, giving the coefficients per job and the results per job (3x3).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the WAIT-state cycle limit; it is used only with the Configuration macro.
REQ-004 Port system1000: input, 1 bit, the single clock; all logic is rising-edge on it.
REQ-005 Port system1000_rst: input, 1 bit, reset; asynchronous assertion, active-high.
REQ-006 Port bus_addr: input, 5 bits, register address; 0..8 coef, 16..24 result, 31 status/control.
REQ-007 Port bus_wr: input, 1 bit, write strobe, valid for one cycle.
REQ-008 Port bus_wdata: input, DATA_W bits, write data.
REQ-009 Port bus_rd: input, 1 bit, read strobe, valid for one cycle.
REQ-010 Port bus_rdata: output, DATA_W+1 bits, read response; bit DATA_W is valid, the low bits are data.
REQ-011 Port core_in: output, DATA_W+1 bits, coefficient stream to the multiply core; bit DATA_W is valid.
REQ-012 Port core_out: input, DATA_W+1 bits, result stream from the core; bit DATA_W is valid.
REQ-013 Port busy: output, 1 bit, high in any state other than IDLE.
REQ-014 Port done_irq: output, 1 bit, one-cycle pulse on job completion.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, WAIT, CAPTURE, DONE.
REQ-016 A write of bit0=1 to address 31 in IDLE SHALL move the FSM to LOAD on the next edge; the same write outside IDLE SHALL be ignored and set sticky status bit2 (start_err).
REQ-017 LOAD SHALL drive core_in = {1, coef[k]} for k = 0..8 on consecutive cycles, in exactly N_WORDS cycles, then enter WAIT; core_in SHALL be {0, 0} in all other states.
REQ-018 In WAIT and CAPTURE, each cycle with core_out valid SHALL store core_out data into result[j], with j incrementing from 0.
REQ-019 The first valid core_out word SHALL move WAIT to CAPTURE.
REQ-020 Storing result[N_WORDS-1] SHALL move the FSM to DONE.
REQ-021 Invalid cycles inside CAPTURE SHALL be tolerated without advancing j.
REQ-022 A core_out valid word arriving in IDLE, LOAD or DONE SHALL be discarded and set sticky status bit3 (overrun).
REQ-023 DONE SHALL last one cycle, pulse done_irq, set sticky status bit1 (done), then return to IDLE.
REQ-024 Coefficient writes (addresses 0..8) SHALL be accepted only in IDLE; in other states they SHALL be dropped and set start_err.
REQ-025 Reads SHALL have 1-cycle latency: the cycle after bus_rd, bus_rdata = {1, data at bus_addr}; every other cycle bus_rdata = {0, 0}.
REQ-026 Reads of unmapped addresses SHALL return {1, 0}.
REQ-027 Reads SHALL be served in every state; a result read during CAPTURE returns the value currently stored.
REQ-028 Status word layout SHALL be: bit0 busy, bit1 done, bit2 start_err, bit3 overrun, bit4 timeout.
REQ-029 Writing 1 to bits 1..4 of address 31 SHALL clear the corresponding sticky bits.
REQ-030 If a sticky bit's set event and its clear fall in the same cycle, the set SHALL win.
REQ-031 If bus_wr and bus_rd are asserted in the same cycle, the write SHALL take effect first and the read SHALL return the new value.
REQ-032 The k and j counters SHALL be ceil(log2(N_WORDS)) bits wide and reset to 0 on every entry to LOAD.

Reset
REQ-033 While system1000_rst is high: FSM = IDLE; k, j and the timeout counter = 0; coef[] and result[] = 0; all sticky bits = 0.
REQ-034 While system1000_rst is high the outputs SHALL be: bus_rdata = {0, 0}, core_in = {0, 0}, busy = 0, done_irq = 0.
REQ-035 Reset asserted mid-job SHALL abort the job with no done_irq.
REQ-036 The first start accepted after reset deassertion SHALL run normally.

Configuration
REQ-037 With macro MATRIX_MULT3X3_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT and CAPTURE and reset on each valid core_out word.
REQ-038 With MATRIX_MULT3X3_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL send the FSM to IDLE, set status bit4 and suppress done_irq.
REQ-039 Without MATRIX_MULT3X3_SEQ_TIMEOUT_EN, WAIT and CAPTURE SHALL wait indefinitely and status bit4 SHALL read 0.

Verification
REQ-040 Write coef 1..9, write 1 to addr 31, core returns 30,24,18,84,69,54,138,114,90 -> core_in valid for 9 cycles with 1..9; done_irq pulses once; reads of 16..24 return those values; status = 0x02.
REQ-041 Write 5 to addr 3 while busy -> coef[3] unchanged; status bit2 = 1; writing 0x04 to addr 31 then reads status bit2 = 0.
REQ-042 Core results with 2 invalid gap cycles between words -> all 9 captured in order; done_irq fires one cycle after the last word.
REQ-043 Assert reset during CAPTURE after 4 words -> busy = 0, result[0..3] = 0, no done_irq; the next job completes normally.
REQ-044 With TIMEOUT_EN and TIMEOUT_CYC = 16, start with no core response -> IDLE 16 cycles after WAIT entry; status = 0x10; no done_irq.
REQ-045 Read addr 20 with no write pending -> bus_rdata valid exactly one cycle later; read addr 12 -> {1, 0}; idle cycles -> {0, 0}.
